execute_md: RTL and testbench

- Parametrised successor of the RV32I execute stage. Same D/X pipeline register, MX/WX operand bypass, ALU, branch resolution and kill generation.
- Adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative multiply/divide unit with a stall handshake back to fetch/decode.
- Sits between decode and memory. Width and multiply latency are generic.

---
 rtl/execute_pkg.sv | 41 ++++
 rtl/execute_md_muldiv.sv | 131 +++++++++++++
 rtl/execute_md.sv | 160 ++++++++++++++++
 tb/tb_execute_md.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// execute_pkg: shared definitions for the execute stage with M-extension.
// Contents: RV opcode constants, ALU operation select, operand-forward
// select codes, M-extension funct3 codes, the multiply/divide FSM state
// type and the default NOP instruction (addi x0, x0, 0).
package execute_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_sel_e;

    localparam logic [1:0] BYP_NONE = 2'd0;
    localparam logic [1:0] BYP_MX   = 2'd1;
    localparam logic [1:0] BYP_WX   = 2'd2;

    localparam logic [2:0] M_MUL    = 3'd0;
    localparam logic [2:0] M_MULH   = 3'd1;
    localparam logic [2:0] M_MULHSU = 3'd2;
    localparam logic [2:0] M_MULHU  = 3'd3;
    localparam logic [2:0] M_DIV    = 3'd4;
    localparam logic [2:0] M_DIVU   = 3'd5;
    localparam logic [2:0] M_REM    = 3'd6;
    localparam logic [2:0] M_REMU   = 3'd7;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h00000013;

endpackage

// File: rtl/execute_md_muldiv.sv
// muldiv_unit: iterative RV M-extension multiply/divide.
// Ports: clk, rst_n (async active-low); start, op (M funct3), a, b in;
//        busy, done, result out.
// Handshake: start is sampled only in IDLE and operands are captured on
// that edge. busy is high while counting (MUL/DIV states); done is high
// for exactly one cycle (DONE) with result valid, then the unit is IDLE.
// The multiply product is formed at capture and the MUL state only
// models latency. Division is restoring, on magnitudes, one quotient bit
// per cycle: the first bit at capture, the remaining XLEN-1 in DIV.
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_r, quo_r, div_r, res_r;
    logic            neg_q_r, neg_r_r, is_rem_r;

    logic              a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, mul_res, special_res;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   st_rem_in, st_quo_in, st_div, st_rem, st_quo;
    logic [XLEN-1:0]   q_fix, r_fix;
    logic [XLEN:0]     rem_sh, diff;
    logic              take;

    always_comb begin
        a_signed = op[2] ? ~op[0] : (op == M_MULH || op == M_MULHSU);
        b_signed = op[2] ? ~op[0] : (op == M_MULH);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        // Sign-extending to 2*XLEN makes one unsigned multiply serve all
        // four signedness combinations.
        a_ext    = {{XLEN{a_neg}}, a};
        b_ext    = {{XLEN{b_neg}}, b};
        prod     = a_ext * b_ext;
        mul_res  = (op == M_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        div_zero = (b == '0);
        div_ovf  = a_signed && (a == SMIN) && (b == '1);
        if (div_zero) special_res = op[1] ? a : '1;
        else          special_res = op[1] ? '0 : a;

        // One restoring step; the capture cycle feeds it from the inputs.
        st_rem_in = (state == MD_IDLE) ? '0    : rem_r;
        st_quo_in = (state == MD_IDLE) ? a_mag : quo_r;
        st_div    = (state == MD_IDLE) ? b_mag : div_r;
        rem_sh    = {st_rem_in, st_quo_in[XLEN-1]};
        diff      = rem_sh - {1'b0, st_div};
        take      = ~diff[XLEN];
        st_rem    = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        st_quo    = {st_quo_in[XLEN-2:0], take};
        q_fix     = neg_q_r ? -st_quo : st_quo;
        r_fix     = neg_r_r ? -st_rem : st_rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MD_IDLE;
            count    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            div_r    <= '0;
            res_r    <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            is_rem_r <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    if (op[2]) begin
                        if (div_zero || div_ovf) begin
                            res_r <= special_res;
                            state <= MD_DONE;
                        end else begin
                            rem_r    <= st_rem;
                            quo_r    <= st_quo;
                            div_r    <= b_mag;
                            neg_q_r  <= a_neg ^ b_neg;
                            neg_r_r  <= a_neg;
                            is_rem_r <= op[1];
                            count    <= CW'(XLEN - 1);
                            state    <= MD_DIV;
                        end
                    end else begin
                        res_r <= mul_res;
                        count <= CW'(MUL_CYCLES - 1);
                        state <= (MUL_CYCLES == 1) ? MD_DONE : MD_MUL;
                    end
                end
                MD_MUL: begin
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= MD_DONE;
                end
                MD_DIV: begin
                    rem_r <= st_rem;
                    quo_r <= st_quo;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        res_r <= is_rem_r ? r_fix : q_fix;
                        state <= MD_DONE;
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy   = (state == MD_MUL) || (state == MD_DIV);
    assign done   = (state == MD_DONE);
    assign result = res_r;

endmodule

// File: rtl/execute_md.sv
// execute_md: execute stage with D/X register, MX/WX bypass, ALU, branch
// resolution, kill generation and an iterative M-extension unit.
// Ports: clk, rst_n (async active-low); PC_d, inst_d, rs1_d, rs2_d from
// decode; alu_m_bypass / wb_w_bypass forward values with rs1_bypass /
// rs2_bypass selects (0 none, 1 MX, 2 WX, 3 none). Outputs: PC_x, inst_x,
// alu_x (valid when stall_dx=0), rs2_x (store data), PCSel, kill_dx,
// stall_dx (hold F/D and X while an M-op is in flight).
module execute_md
    import execute_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          MUL_CYCLES = 2,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PC_d,
    input  logic [31:0]     inst_d,
    input  logic [XLEN-1:0] rs1_d,
    input  logic [XLEN-1:0] rs2_d,
    input  logic [XLEN-1:0] alu_m_bypass,
    input  logic [XLEN-1:0] wb_w_bypass,
    input  logic [1:0]      rs1_bypass,
    input  logic [1:0]      rs2_bypass,
    output logic [XLEN-1:0] PC_x,
    output logic [31:0]     inst_x,
    output logic [XLEN-1:0] alu_x,
    output logic [XLEN-1:0] rs2_x,
    output logic            PCSel,
    output logic            kill_dx,
    output logic            stall_dx
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] rs1_q, rs2_q, rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] op_a, op_b, imm, alu_res, alu_base, md_result;
    logic [31:0]     imm32;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [SHW-1:0]  shamt;
    alu_sel_e        alu_sel;
    logic            is_m, md_start, md_busy, md_done, taken, redirect;

    assign opcode = inst_x[6:0];
    assign funct3 = inst_x[14:12];
    assign funct7 = inst_x[31:25];

    always_comb begin
        rs1_fwd = (rs1_bypass == BYP_MX) ? alu_m_bypass :
                  (rs1_bypass == BYP_WX) ? wb_w_bypass  : rs1_q;
        rs2_fwd = (rs2_bypass == BYP_MX) ? alu_m_bypass :
                  (rs2_bypass == BYP_WX) ? wb_w_bypass  : rs2_q;

        case (opcode)
            OP_JALR, OP_LCC, OP_MCC: imm32 = {{20{inst_x[31]}}, inst_x[31:20]};
            OP_SCC:   imm32 = {{20{inst_x[31]}}, inst_x[31:25], inst_x[11:7]};
            OP_BCC:   imm32 = {{19{inst_x[31]}}, inst_x[31], inst_x[7],
                               inst_x[30:25], inst_x[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {inst_x[31:12], 12'b0};
            OP_JAL:   imm32 = {{12{inst_x[31]}}, inst_x[19:12], inst_x[20],
                               inst_x[30:21], 1'b0};
            default:  imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));

        op_a  = (opcode == OP_JAL || opcode == OP_AUIPC || opcode == OP_BCC) ? PC_x : rs1_fwd;
        op_b  = (opcode == OP_RCC) ? rs2_fwd : imm;
        shamt = op_b[SHW-1:0];

        alu_sel = ALU_ADD;
        if (opcode == OP_LUI) begin
            alu_sel = ALU_PASSB;
        end else if (opcode == OP_MCC || opcode == OP_RCC) begin
            case (funct3)
                3'b000:  alu_sel = (opcode == OP_RCC && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_sel = ALU_SLL;
                3'b010:  alu_sel = ALU_SLT;
                3'b011:  alu_sel = ALU_SLTU;
                3'b100:  alu_sel = ALU_XOR;
                3'b101:  alu_sel = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_sel = ALU_OR;
                default: alu_sel = ALU_AND;
            endcase
        end

        case (alu_sel)
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU:  alu_res = XLEN'(op_a < op_b);
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = $signed(op_a) >>> shamt;
            ALU_OR:    alu_res = op_a | op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = op_a + op_b;
        endcase
        alu_base = (opcode == OP_JALR) ? {alu_res[XLEN-1:1], 1'b0} : alu_res;

        case (funct3)
            3'b000:  taken = (rs1_fwd == rs2_fwd);
            3'b001:  taken = (rs1_fwd != rs2_fwd);
            3'b100:  taken = ($signed(rs1_fwd) <  $signed(rs2_fwd));
            3'b101:  taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            3'b110:  taken = (rs1_fwd <  rs2_fwd);
            3'b111:  taken = (rs1_fwd >= rs2_fwd);
            default: taken = 1'b0;
        endcase
        redirect = (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BCC && taken);
    end

    // While DONE the finished M-op is still in X and must not restart;
    // the next instruction is examined only once the unit is back in IDLE.
    assign is_m     = (opcode == OP_RCC) && (funct7 == FUNCT7_M);
    assign md_start = is_m && !md_busy && !md_done;
    assign stall_dx = md_busy || md_start;
    assign PCSel    = redirect && !stall_dx;
    assign kill_dx  = PCSel;
    assign alu_x    = md_done ? md_result : alu_base;
    assign rs2_x    = rs2_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_x   <= '0;
            inst_x <= NOP_INST;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else if (stall_dx) begin
            PC_x   <= PC_x;
        end else if (kill_dx) begin
            PC_x   <= '0;
            inst_x <= NOP_INST;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else begin
            PC_x   <= PC_d;
            inst_x <= inst_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
        end
    end

    muldiv_unit #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (funct3),
        .a      (rs1_fwd),
        .b      (rs2_fwd),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: directed vectors for execute_md. Each issued instruction
// pushes {pcsel, stall_cycles, alu_x} into exp_q; the monitor pops one
// entry whenever a non-NOP instruction sits unstalled in X.
module tb_execute_md;
  import execute_pkg::*;

  localparam logic [31:0] NOP = 32'h00000013;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] PC_d, inst_d, rs1_d, rs2_d, alu_m_bypass, wb_w_bypass;
  logic [1:0]  rs1_bypass, rs2_bypass;
  logic [31:0] PC_x, inst_x, alu_x, rs2_x;
  logic        PCSel, kill_dx, stall_dx;

  execute_md #(.XLEN(32), .MUL_CYCLES(2), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .PC_d(PC_d), .inst_d(inst_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .alu_m_bypass(alu_m_bypass),
    .wb_w_bypass(wb_w_bypass), .rs1_bypass(rs1_bypass), .rs2_bypass(rs2_bypass),
    .PC_x(PC_x), .inst_x(inst_x), .alu_x(alu_x), .rs2_x(rs2_x),
    .PCSel(PCSel), .kill_dx(kill_dx), .stall_dx(stall_dx)
  );

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  int stall_cnt = 0;
  logic [39:0] mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
    end else if (stall_dx) begin
      stall_cnt++;
    end else if (inst_x != NOP) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_x: inst_x=%h alu_x=%h with empty expected queue", inst_x, alu_x);
      end else begin
        mon_e = exp_q.pop_front();
        check("alu_x", alu_x, mon_e[31:0]);
        check("stall_cycles", 32'(stall_cnt), 32'(mon_e[38:32]));
        check("pcsel", 32'(PCSel), 32'(mon_e[39]));
        check("kill_dx", 32'(kill_dx), 32'(mon_e[39]));
      end
      stall_cnt = 0;
    end
  end

  // driver tasks: called at posedge+1
  task automatic finish_x(input logic [31:0] exp_alu, input int exp_stall,
                          input logic exp_pcsel, input logic [31:0] next_d);
    int n;
    exp_q.push_back({exp_pcsel, 7'(exp_stall), exp_alu});
    inst_d = next_d;
    PC_d = 32'h0;
    n = 0;
    while (stall_dx && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (stall_dx) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: stall_dx still %b after %0d cycles, required 0", stall_dx, n);
    end
    @(posedge clk); #1;
    inst_d = NOP;
  endtask

  task automatic run_inst(input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] mx, input logic [31:0] wx,
                          input logic [31:0] exp_alu, input int exp_stall,
                          input logic exp_pcsel, input logic [31:0] next_d);
    inst_d = inst; PC_d = pc; rs1_d = a; rs2_d = b;
    rs1_bypass = s1; rs2_bypass = s2; alu_m_bypass = mx; wb_w_bypass = wx;
    @(posedge clk); #1;
    finish_x(exp_alu, exp_stall, exp_pcsel, next_d);
  endtask

  function automatic logic [31:0] r_inst(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // branch x1,x2 with offset +16
  function automatic logic [31:0] b_inst(input logic [2:0] f3);
    return {1'b0, 6'b0, 5'd2, 5'd1, f3, 4'b1000, 1'b0, 7'b1100011};
  endfunction

  localparam logic [31:0] ADDI_M1 = {12'hFFF, 5'd1, 3'b000, 5'd3, 7'b0010011};
  localparam logic [31:0] LUI_I   = {20'h12345, 5'd3, 7'b0110111};
  localparam logic [31:0] JAL_8   = {1'b0, 10'b0000000100, 1'b0, 8'b0, 5'd1, 7'b1101111};

  initial begin
    PC_d = '0; inst_d = NOP; rs1_d = '0; rs2_d = '0;
    alu_m_bypass = '0; wb_w_bypass = '0; rs1_bypass = BYP_NONE; rs2_bypass = BYP_NONE;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst_x", inst_x, NOP);
    check("rst_alu_x", alu_x, 32'h0);
    check("rst_rs2_x", rs2_x, 32'h0);
    check("rst_fsm", 32'(dut.u_md.state), 32'(MD_IDLE));
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_inst_x", inst_x, NOP);
      check("idle_pc_x", PC_x, 32'h0);
      check("idle_stall", 32'(stall_dx), 32'h0);
      check("idle_pcsel", 32'(PCSel), 32'h0);
    end
    @(posedge clk); #1;

    // base ALU with bypass
    run_inst(r_inst(7'h00, 3'b000), 32'h10, 32'd99, 32'd7, BYP_MX, BYP_NONE, 32'd5, 32'd0, 32'd12, 0, 1'b0, NOP);
    run_inst(r_inst(7'h00, 3'b000), 32'h14, 32'd20, 32'd1, 2'd3, BYP_NONE, 32'd5, 32'd6, 32'd21, 0, 1'b0, NOP);
    run_inst(r_inst(7'h20, 3'b000), 32'h18, 32'd10, 32'd50, BYP_NONE, BYP_WX, 32'd0, 32'd3, 32'd7, 0, 1'b0, NOP);
    run_inst(ADDI_M1, 32'h1C, 32'd10, 32'd0, BYP_NONE, BYP_NONE, 32'd0, 32'd0, 32'd9, 0, 1'b0, NOP);
    run_inst(LUI_I, 32'h20, 32'd0, 32'd0, BYP_NONE, BYP_NONE, 32'd0, 32'd0, 32'h12345000, 0, 1'b0, NOP);

    // multiply, including MULHU issued back-to-back behind MUL
    run_inst(r_inst(7'h01, M_MUL), 32'h24, 32'hFFFFFFFF, 32'hFFFFFFFF, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'h00000001, 2, 1'b0, r_inst(7'h01, M_MULHU));
    finish_x(32'hFFFFFFFE, 2, 1'b0, NOP);
    run_inst(r_inst(7'h01, M_MULH), 32'h28, 32'hFFFFFFFF, 32'hFFFFFFFF, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'h00000000, 2, 1'b0, NOP);
    run_inst(r_inst(7'h01, M_MULHSU), 32'h2C, 32'hFFFFFFFF, 32'hFFFFFFFF, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'hFFFFFFFF, 2, 1'b0, NOP);

    // divide
    run_inst(r_inst(7'h01, M_DIV), 32'h30, 32'hFFFFFFF9, 32'd2, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'hFFFFFFFD, 32, 1'b0, NOP);
    run_inst(r_inst(7'h01, M_REM), 32'h34, 32'hFFFFFFF9, 32'd2, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'hFFFFFFFF, 32, 1'b0, NOP);
    run_inst(r_inst(7'h01, M_DIVU), 32'h38, 32'd100, 32'd7, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'd14, 32, 1'b0, NOP);
    run_inst(r_inst(7'h01, M_DIVU), 32'h3C, 32'h1234, 32'd0, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'hFFFFFFFF, 1, 1'b0, NOP);
    run_inst(r_inst(7'h01, M_REMU), 32'h40, 32'h1234, 32'd0, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'h00001234, 1, 1'b0, NOP);
    run_inst(r_inst(7'h01, M_DIV), 32'h44, 32'h80000000, 32'hFFFFFFFF, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'h80000000, 1, 1'b0, NOP);
    run_inst(r_inst(7'h01, M_REM), 32'h48, 32'h80000000, 32'hFFFFFFFF, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'h00000000, 1, 1'b0, NOP);

    // branches and jump; the taken BEQ must squash the ADD behind it
    run_inst(b_inst(3'b000), 32'h100, 32'd9, 32'd9, BYP_NONE, BYP_NONE, 32'd0, 32'd0,
             32'h110, 0, 1'b1, r_inst(7'h00, 3'b000));
    check("kill_inst_x", inst_x, NOP);
    check("kill_pc_x", PC_x, 32'h0);
    run_inst(b_inst(3'b001), 32'h100, 32'd9, 32'd9, BYP_NONE, BYP_NONE, 32'd0, 32'd0, 32'h110, 0, 1'b0, NOP);
    run_inst(b_inst(3'b100), 32'h100, 32'hFFFFFFFF, 32'd1, BYP_NONE, BYP_NONE, 32'd0, 32'd0, 32'h110, 0, 1'b1, NOP);
    run_inst(b_inst(3'b110), 32'h100, 32'hFFFFFFFF, 32'd1, BYP_NONE, BYP_NONE, 32'd0, 32'd0, 32'h110, 0, 1'b0, NOP);
    run_inst(JAL_8, 32'h200, 32'd0, 32'd0, BYP_NONE, BYP_NONE, 32'd0, 32'd0, 32'h208, 0, 1'b1, NOP);

    // reset in the middle of a divide
    inst_d = r_inst(7'h01, M_DIV); PC_d = 32'h300; rs1_d = 32'd100; rs2_d = 32'd3;
    rs1_bypass = BYP_NONE; rs2_bypass = BYP_NONE;
    @(posedge clk); #1;
    inst_d = NOP;
    repeat (5) @(posedge clk);
    #1;
    check("mid_div_stall", 32'(stall_dx), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_stall", 32'(stall_dx), 32'h0);
    check("abort_fsm", 32'(dut.u_md.state), 32'(MD_IDLE));
    check("abort_inst_x", inst_x, NOP);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_abort_stall", 32'(stall_dx), 32'h0);
    check("post_abort_fsm", 32'(dut.u_md.state), 32'(MD_IDLE));

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
